rob_ring: RTL and testbench

Parametrised circular reorder buffer for the out-of-order core. It allocates entries in program order from rename/dispatch and accepts completions from N_CPL execution channels, addressed by ROB tag rather than PC. It retires up to RET_W completed entries per cycle, in order, toward the ARF, the free list and the LSQ. Head/tail pointers replace linear scans, and a registered retire stage makes its timing deterministic.

---
 rtl/rob_pkg.sv | 27 ++
 rtl/rob_ring_if.sv | 40 ++++
 rtl/rob_retire_sel.sv | 34 +++
 rtl/rob_ring.sv | 145 ++++++++++++++
 tb/tb_rob_ring.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer.
package rob_pkg;

  localparam int unsigned DefDepth = 64;
  localparam int unsigned DefNCpl  = 3;
  localparam int unsigned DefRetW  = 2;
  localparam int unsigned DefPregW = 6;

  typedef struct packed {
    logic                valid;
    logic                complete;
    logic                is_store;
    logic [DefPregW-1:0] dr;
    logic [DefPregW-1:0] old_dr;
    logic [31:0]         pc;
    logic [31:0]         data;
  } rob_entry_t;

  typedef struct packed {
    logic                is_store;
    logic [DefPregW-1:0] dr;
    logic [DefPregW-1:0] old_dr;
    logic [31:0]         pc;
    logic [31:0]         data;
  } rob_ret_lane_t;

endpackage

// File: rtl/rob_ring_if.sv
// Dispatch, completion and retire bundle of the reorder buffer.
interface rob_ring_if #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned N_CPL  = 3,
  parameter int unsigned RET_W  = 2,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
);
  logic                    disp_valid;
  logic                    disp_ready;
  logic [PREG_W-1:0]       disp_dr;
  logic [PREG_W-1:0]       disp_old_dr;
  logic [31:0]             disp_pc;
  logic                    disp_is_store;
  logic [IDX_W-1:0]        disp_tag;
  logic [N_CPL-1:0]        cpl_valid;
  logic [N_CPL*IDX_W-1:0]  cpl_tag;
  logic [N_CPL*32-1:0]     cpl_data;
  logic [RET_W-1:0]        ret_valid;
  logic [RET_W*PREG_W-1:0] ret_dr;
  logic [RET_W*PREG_W-1:0] ret_old_dr;
  logic [RET_W*32-1:0]     ret_data;
  logic [RET_W*32-1:0]     ret_pc;
  logic [RET_W-1:0]        ret_is_store;
  logic [IDX_W:0]          count;

  modport master (
    output disp_valid, disp_dr, disp_old_dr, disp_pc, disp_is_store,
    output cpl_valid, cpl_tag, cpl_data,
    input  disp_ready, disp_tag, ret_valid, ret_dr, ret_old_dr, ret_data, ret_pc,
    input  ret_is_store, count
  );

  modport slave (
    input  disp_valid, disp_dr, disp_old_dr, disp_pc, disp_is_store,
    input  cpl_valid, cpl_tag, cpl_data,
    output disp_ready, disp_tag, ret_valid, ret_dr, ret_old_dr, ret_data, ret_pc,
    output ret_is_store, count
  );
endinterface

// File: rtl/rob_retire_sel.sv
// Prefix scan from head: counts the in-order run of valid+complete entries, up to RET_W.
module rob_retire_sel #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned RET_W = 2,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0]       i_head,
  input  logic [DEPTH-1:0]       i_valid,
  input  logic [DEPTH-1:0]       i_complete,
  output logic [2:0]             o_n,
  output logic [RET_W*IDX_W-1:0] o_lane_idx
);

  logic             w_run;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_n        = '0;
    o_lane_idx = '0;
    w_run      = 1'b1;
    w_idx      = '0;
    for (int l = 0; l < RET_W; l++) begin
      // Truncating add wraps the index past DEPTH-1.
      w_idx = i_head + IDX_W'(l);
      o_lane_idx[l*IDX_W +: IDX_W] = w_idx;
      if (w_run && i_valid[w_idx] && i_complete[w_idx]) begin
        o_n = 3'(l + 1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_ring.sv
// Circular reorder buffer: in-order dispatch, tagged completion, registered in-order retire.
// Optional flush port and logic enabled by defining ROB_FLUSH_EN.
module rob_ring import rob_pkg::*; #(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned N_CPL  = DefNCpl,
  parameter int unsigned RET_W  = DefRetW,
  parameter int unsigned PREG_W = DefPregW
) (
  input logic       clk,
  input logic       rst,
  rob_ring_if.slave bus
`ifdef ROB_FLUSH_EN
  ,
  input logic       flush
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  rob_entry_t             r_entries [DEPTH];
  rob_entry_t             w_entries_d [DEPTH];
  logic [IDX_W-1:0]       r_head, r_tail;
  logic [CNT_W-1:0]       r_count;
  rob_ret_lane_t          r_ret [RET_W];
  logic [RET_W-1:0]       r_ret_valid;
  logic [DEPTH-1:0]       w_valid_vec, w_cpl_vec;
  logic [2:0]             w_ret_n;
  logic [RET_W*IDX_W-1:0] w_lane_flat;
  logic [IDX_W-1:0]       w_lane_idx [RET_W];
  logic [IDX_W-1:0]       w_cpl_tag [N_CPL];
  logic                   w_disp_ready;
  logic                   w_accept;

  always_comb begin
    w_disp_ready = !rst && (r_count != CNT_W'(DEPTH));
`ifdef ROB_FLUSH_EN
    if (flush) w_disp_ready = 1'b0;
`endif
  end

  assign w_accept = bus.disp_valid && w_disp_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_vec[i] = r_entries[i].valid;
      w_cpl_vec[i]   = r_entries[i].complete;
    end
    for (int l = 0; l < RET_W; l++) w_lane_idx[l] = w_lane_flat[l*IDX_W +: IDX_W];
    for (int c = 0; c < N_CPL; c++) w_cpl_tag[c] = bus.cpl_tag[c*IDX_W +: IDX_W];
  end

  rob_retire_sel #(
    .DEPTH (DEPTH),
    .RET_W (RET_W),
    .IDX_W (IDX_W)
  ) u_retire_sel (
    .i_head     (r_head),
    .i_valid    (w_valid_vec),
    .i_complete (w_cpl_vec),
    .o_n        (w_ret_n),
    .o_lane_idx (w_lane_flat)
  );

  // Retire, dispatch and completion never touch the same slot in one cycle, so order is free.
  always_comb begin
    w_entries_d = r_entries;
    for (int l = 0; l < RET_W; l++) begin
      if (l < 32'(w_ret_n)) begin
        w_entries_d[w_lane_idx[l]].valid    = 1'b0;
        w_entries_d[w_lane_idx[l]].complete = 1'b0;
      end
    end
    if (w_accept) begin
      w_entries_d[r_tail].valid    = 1'b1;
      w_entries_d[r_tail].complete = 1'b0;
      w_entries_d[r_tail].is_store = bus.disp_is_store;
      w_entries_d[r_tail].dr       = DefPregW'(bus.disp_dr);
      w_entries_d[r_tail].old_dr   = DefPregW'(bus.disp_old_dr);
      w_entries_d[r_tail].pc       = bus.disp_pc;
      w_entries_d[r_tail].data     = '0;
    end
    // Walk channels high to low so the lowest index writes last and wins.
    for (int c = N_CPL - 1; c >= 0; c--) begin
      if (bus.cpl_valid[c] && r_entries[w_cpl_tag[c]].valid &&
          !r_entries[w_cpl_tag[c]].complete) begin
        w_entries_d[w_cpl_tag[c]].complete = 1'b1;
        w_entries_d[w_cpl_tag[c]].data     =
            r_entries[w_cpl_tag[c]].is_store ? 32'h0 : bus.cpl_data[c*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ret_valid <= '0;
      for (int l = 0; l < RET_W; l++) r_ret[l] <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ret_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end
`endif
    else begin
      r_entries <= w_entries_d;
      r_head    <= r_head + IDX_W'(w_ret_n);
      r_tail    <= r_tail + IDX_W'(w_accept);
      r_count   <= r_count + CNT_W'(w_accept) - CNT_W'(w_ret_n);
      for (int l = 0; l < RET_W; l++) begin
        if (l < 32'(w_ret_n)) begin
          r_ret_valid[l]     <= 1'b1;
          r_ret[l].is_store  <= r_entries[w_lane_idx[l]].is_store;
          r_ret[l].dr        <= r_entries[w_lane_idx[l]].dr;
          r_ret[l].old_dr    <= r_entries[w_lane_idx[l]].old_dr;
          r_ret[l].pc        <= r_entries[w_lane_idx[l]].pc;
          r_ret[l].data      <= r_entries[w_lane_idx[l]].data;
        end else begin
          r_ret_valid[l] <= 1'b0;
        end
      end
    end
  end

  assign bus.disp_ready = w_disp_ready;
  assign bus.disp_tag   = r_tail;
  assign bus.count      = r_count;
  assign bus.ret_valid  = r_ret_valid;

  for (genvar l = 0; l < RET_W; l++) begin : g_ret
    assign bus.ret_dr[l*PREG_W +: PREG_W]     = PREG_W'(r_ret[l].dr);
    assign bus.ret_old_dr[l*PREG_W +: PREG_W] = PREG_W'(r_ret[l].old_dr);
    assign bus.ret_data[l*32 +: 32]           = r_ret[l].data;
    assign bus.ret_pc[l*32 +: 32]             = r_ret[l].pc;
    assign bus.ret_is_store[l]                = r_ret[l].is_store;
  end

endmodule

// File: tb/tb_rob_ring.sv
// Scoreboard bench for rob_ring: dispatch pushes expected retirements, a monitor pops on ret_valid.
module tb_rob_ring;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned N_CPL  = 3;
  localparam int unsigned RET_W  = 2;
  localparam int unsigned PREG_W = 6;
  localparam int unsigned IDX_W  = 6;

  typedef struct packed {
    logic [PREG_W-1:0] dr;
    logic [PREG_W-1:0] old_dr;
    logic [31:0]       pc;
    logic [31:0]       data;
    logic              is_store;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_ring_if #(
    .DEPTH  (DEPTH),
    .N_CPL  (N_CPL),
    .RET_W  (RET_W),
    .PREG_W (PREG_W)
  ) bus ();

`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif

  rob_ring #(
    .DEPTH  (DEPTH),
    .N_CPL  (N_CPL),
    .RET_W  (RET_W),
    .PREG_W (PREG_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus)
`ifdef ROB_FLUSH_EN
    ,
    .flush (flush)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every retire lane with ret_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [RET_W-1:0] v;
    exp_t e;
    v = bus.ret_valid;
    if (!rst && v != '0) begin
      check("ret_contig", 64'(((v + RET_W'(1)) & v) == '0), 64'd1);
      for (int l = 0; l < RET_W; l++) begin
        if (v[l]) begin
          if (exp_q.size() == 0) begin
            check("ret_unexpected", 64'(v), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("ret_dr", 64'(bus.ret_dr[l*PREG_W +: PREG_W]), 64'(e.dr));
            check("ret_old_dr", 64'(bus.ret_old_dr[l*PREG_W +: PREG_W]), 64'(e.old_dr));
            check("ret_pc", 64'(bus.ret_pc[l*32 +: 32]), 64'(e.pc));
            check("ret_data", 64'(bus.ret_data[l*32 +: 32]), 64'(e.data));
            check("ret_is_store", 64'(bus.ret_is_store[l]), 64'(e.is_store));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpl(input int ch, input int tag, input logic [31:0] data);
    bus.cpl_valid[ch]                = 1'b1;
    bus.cpl_tag[ch*IDX_W +: IDX_W]   = IDX_W'(tag);
    bus.cpl_data[ch*32 +: 32]        = data;
  endtask

  // Dispatch one entry; optionally record the retirement it should eventually produce.
  task automatic dispatch(input int dr, input logic st, input logic [31:0] exp_data,
                          input int exp_tag, input bit track);
    exp_t e;
    bus.disp_valid    = 1'b1;
    bus.disp_dr       = PREG_W'(dr);
    bus.disp_old_dr   = PREG_W'(dr + 20);
    bus.disp_pc       = 32'h1000 + 32'(dr * 4);
    bus.disp_is_store = st;
    check("disp_ready", 64'(bus.disp_ready), 64'd1);
    check("disp_tag", 64'(bus.disp_tag), 64'(exp_tag));
    if (track) begin
      e.dr       = PREG_W'(dr);
      e.old_dr   = PREG_W'(dr + 20);
      e.pc       = 32'h1000 + 32'(dr * 4);
      e.data     = exp_data;
      e.is_store = st;
      exp_q.push_back(e);
    end
    tick();
    bus.disp_valid    = 1'b0;
    bus.disp_is_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ctag[64];
    logic [31:0] cdat[64];
    bus.disp_valid    = 1'b0;
    bus.disp_dr       = '0;
    bus.disp_old_dr   = '0;
    bus.disp_pc       = '0;
    bus.disp_is_store = 1'b0;
    bus.cpl_valid     = '0;
    bus.cpl_tag       = '0;
    bus.cpl_data      = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_ret_valid", 64'(bus.ret_valid), 64'd0);
    check("rst_disp_tag", 64'(bus.disp_tag), 64'd0);
    check("rst_disp_ready", 64'(bus.disp_ready), 64'd0);
    check("rst_ret_dr", 64'(bus.ret_dr), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(bus.disp_ready), 64'd1);

    // Four entries completed youngest-first retire as two full pairs
    for (int i = 0; i < 4; i++) dispatch(10 + i, 1'b0, 32'hA0 + 32'(i), i, 1'b1);
    check("count_4", 64'(bus.count), 64'd4);
    for (int i = 3; i >= 0; i--) begin
      set_cpl(0, i, 32'hA0 + 32'(i));
      tick();
    end
    bus.cpl_valid = '0;
    check("no_ret_before_head", 64'(bus.ret_valid), 64'd0);
    tick();
    check("pair1_valid", 64'(bus.ret_valid), 64'b11);
    check("pair1_dr", 64'(bus.ret_dr), 64'({6'd11, 6'd10}));
    tick();
    check("pair2_valid", 64'(bus.ret_valid), 64'b11);
    check("pair2_dr", 64'(bus.ret_dr), 64'({6'd13, 6'd12}));
    tick();
    check("pair_done_valid", 64'(bus.ret_valid), 64'd0);
    check("pair_done_count", 64'(bus.count), 64'd0);

    // Incomplete head blocks younger completed entries (tags 4,5,6)
    for (int i = 4; i < 7; i++) dispatch(i, 1'b0, 32'hB0 + 32'(i), i, 1'b1);
    set_cpl(0, 6, 32'hB6);
    tick();
    set_cpl(0, 5, 32'hB5);
    tick();
    bus.cpl_valid = '0;
    tick();
    tick();
    check("blocked_valid", 64'(bus.ret_valid), 64'd0);
    check("blocked_count", 64'(bus.count), 64'd3);
    set_cpl(0, 4, 32'hB4);
    tick();
    bus.cpl_valid = '0;
    tick();
    check("unblock_valid", 64'(bus.ret_valid), 64'b11);
    tick();
    check("tail_valid", 64'(bus.ret_valid), 64'b01);
    tick();
    check("blocked_drained", 64'(bus.count), 64'd0);

    // Same tag on channels 0 and 2: channel 0 data wins
    dispatch(7, 1'b0, 32'h11, 7, 1'b1);
    set_cpl(0, 7, 32'h11);
    set_cpl(2, 7, 32'h22);
    tick();
    bus.cpl_valid = '0;
    tick();
    check("dup_valid", 64'(bus.ret_valid), 64'b01);
    check("dup_data", 64'(bus.ret_data[31:0]), 64'h11);

    // Store result data is forced to zero
    dispatch(8, 1'b1, 32'h0, 8, 1'b1);
    set_cpl(1, 8, 32'hDEAD);
    tick();
    bus.cpl_valid = '0;
    tick();
    check("store_valid", 64'(bus.ret_valid), 64'b01);
    check("store_flag", 64'(bus.ret_is_store[0]), 64'd1);
    check("store_data", 64'(bus.ret_data[31:0]), 64'd0);

    // Reset with entries in flight discards them
    dispatch(30, 1'b0, 32'h0, 9, 1'b0);
    dispatch(31, 1'b0, 32'h0, 10, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_count", 64'(bus.count), 64'd0);
    check("midrst_ready", 64'(bus.disp_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("midrst_ret_valid", 64'(bus.ret_valid), 64'd0);
    check("midrst_tag", 64'(bus.disp_tag), 64'd0);

    // Fill to DEPTH, then free two slots and dispatch across the wrap
    for (int t = 0; t < 64; t++) dispatch(t % 32, 1'b0, 32'h100 + 32'(t), t, 1'b1);
    check("full_count", 64'(bus.count), 64'd64);
    check("full_ready", 64'(bus.disp_ready), 64'd0);
    bus.disp_valid = 1'b1;
    tick();
    bus.disp_valid = 1'b0;
    check("full_reject_count", 64'(bus.count), 64'd64);
    check("full_tag_wrapped", 64'(bus.disp_tag), 64'd0);
    set_cpl(0, 0, 32'h100);
    set_cpl(1, 1, 32'h101);
    tick();
    bus.cpl_valid = '0;
    tick();
    check("freed_valid", 64'(bus.ret_valid), 64'b11);
    check("freed_count", 64'(bus.count), 64'd62);
    check("freed_ready", 64'(bus.disp_ready), 64'd1);
    dispatch(40, 1'b0, 32'h200, 0, 1'b1);
    dispatch(41, 1'b0, 32'h201, 1, 1'b1);
    check("refull_count", 64'(bus.count), 64'd64);
    for (int t = 2; t < 64; t++) begin
      ctag[t-2] = t;
      cdat[t-2] = 32'h100 + 32'(t);
    end
    ctag[62] = 0;
    cdat[62] = 32'h200;
    ctag[63] = 1;
    cdat[63] = 32'h201;
    for (int k = 0; k < 64; k += 3) begin
      for (int c = 0; c < 3; c++) if (k + c < 64) set_cpl(c, ctag[k+c], cdat[k+c]);
      tick();
      bus.cpl_valid = '0;
    end
    for (int i = 0; i < 200 && bus.count != 0; i++) tick();
    check("wrap_drain_count", 64'(bus.count), 64'd0);
    tick();
    check("wrap_drain_valid", 64'(bus.ret_valid), 64'd0);

`ifdef ROB_FLUSH_EN
    // Flush with five entries in flight
    for (int i = 0; i < 5; i++) dispatch(50 + i, 1'b0, 32'h0, 2 + i, 1'b0);
    check("preflush_count", 64'(bus.count), 64'd5);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(bus.disp_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_tag", 64'(bus.disp_tag), 64'd0);
    tick();
    check("flush_ret_valid", 64'(bus.ret_valid), 64'd0);
`endif

    tick();
    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
